// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard and sequencing controller for a 5-stage MIPS pipeline.
// It produces the stall, flush and forwarding controls for the F/D, D/E and
// E/M pipeline registers. It also holds the E stage while a multi-cycle
// MUL/DIV is in progress, and it keeps a saturating count of stalled cycles.
//
// Sequencer states:
//   state   | meaning
//   IDLE    | no MUL/DIV in flight; a MUL/DIV arriving in E starts a sequence
//   BUSY    | MUL/DIV occupying E; cnt counts down to the done cycle (cnt==1)
//
// MD_LATENCY must lie in the range 2..15 because the down-counter is 4 bits wide.

module pipeline_hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic             BranchD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic             MulDivStartE,
  input  logic [4:0]       WriteRegM,
  input  logic             RegWriteM,
  input  logic             MemtoRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteW,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic             StallE,
  output logic             FlushM,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MulDivBusy,
  output logic             MulDivDoneE,
  output logic [CNT_W-1:0] StallCount
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 1);
  localparam logic [3:0] CNT_LAST = 4'd1;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [CNT_W-1:0] STALL_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [1:0]       w_fwd_ae;
  logic [1:0]       w_fwd_be;
  logic             w_fwd_ad;
  logic             w_fwd_bd;

  logic             w_lwstall;
  logic             w_branchstall;
  logic             w_mdstall;
  logic             w_md_busy;
  logic             w_md_done;
  logic             w_hazard_stall;
  logic             w_stall_front;

  // E-stage ALU operand forwarding. A result in M is newer than one in W, so M wins.
  always_comb begin
    w_fwd_ae = FWD_RF;
    if (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RsE)) begin
      w_fwd_ae = FWD_M;
    end else if (RegWriteW && (WriteRegW != 5'd0) && (WriteRegW == RsE)) begin
      w_fwd_ae = FWD_W;
    end

    w_fwd_be = FWD_RF;
    if (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RtE)) begin
      w_fwd_be = FWD_M;
    end else if (RegWriteW && (WriteRegW != 5'd0) && (WriteRegW == RtE)) begin
      w_fwd_be = FWD_W;
    end
  end

  // D-stage branch-compare forwarding from M. Register 0 is hard-wired, so it never forwards.
  always_comb begin
    w_fwd_ad = (RsD != 5'd0) && RegWriteM && (WriteRegM == RsD);
    w_fwd_bd = (RtD != 5'd0) && RegWriteM && (WriteRegM == RtD);
  end

  // Data hazards that forwarding cannot cover: load-use, and a branch whose operands are still in flight.
  always_comb begin
    w_lwstall = MemtoRegE && ((RtE == RsD) || (RtE == RtD));

    w_branchstall = BranchD &&
                    ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                     (MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));
  end

  // Sequencer next state. MulDivStartE is only looked at in IDLE, so a held start does not restart BUSY.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (MulDivStartE) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = MD_LOAD;
        end
      end
      ST_BUSY: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Sequencer state and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The first E cycle of a MUL/DIV stalls (from IDLE), then every BUSY cycle except the done cycle stalls.
  always_comb begin
    w_md_busy = (r_state == ST_BUSY);
    w_md_done = w_md_busy && (r_cnt == CNT_LAST);
    w_mdstall = ((r_state == ST_IDLE) && MulDivStartE) ||
                (w_md_busy && (r_cnt != CNT_LAST));
    w_hazard_stall = w_lwstall || w_branchstall;
    w_stall_front  = !reset && (w_hazard_stall || w_mdstall);
  end

  // Stall and flush outputs. Reset forces a bubble into E and releases every hold.
  // A held E is never flushed, so a MUL/DIV in progress is not lost.
  always_comb begin
    StallF      = w_stall_front;
    StallD      = w_stall_front;
    StallE      = !reset && w_mdstall;
    FlushM      = !reset && w_mdstall;
    FlushE      = reset || (w_hazard_stall && !w_mdstall);
    MulDivBusy  = !reset && w_md_busy;
    MulDivDoneE = !reset && w_md_done;
    ForwardAE   = w_fwd_ae;
    ForwardBE   = w_fwd_be;
    ForwardAD   = w_fwd_ad;
    ForwardBD   = w_fwd_bd;
  end

  // Saturating stall-cycle counter. It stops at all-ones and never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall_front && (r_stall_cnt != STALL_MAX)) begin
      r_stall_cnt <= r_stall_cnt + STALL_ONE;
    end
  end

  assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (MD_LATENCY=4, CNT_W=4).
// Each cycle's expected outputs are pushed to a queue when the stimulus is driven.
// They are popped and compared at the following falling edge.
// Packed layout of one expected word:
//   {StallF,StallD,FlushE,StallE,FlushM,ForwardAD,ForwardBD,ForwardAE,ForwardBE,MulDivBusy,MulDivDoneE,StallCount}

module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       BranchD, RegWriteE, MemtoRegE, MulDivStartE;
  logic       RegWriteM, MemtoRegM, RegWriteW;
  logic       StallF, StallD, FlushE, StallE, FlushM, ForwardAD, ForwardBD;
  logic [1:0] ForwardAE, ForwardBE;
  logic       MulDivBusy, MulDivDoneE;
  logic [3:0] StallCount;

  logic [16:0] q_exp[$];
  logic [3:0]  m_cnt;
  int          n_run;
  int          n_fail;

  pipeline_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .RsD(RsD), .RtD(RtD), .BranchD(BranchD),
    .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MulDivStartE(MulDivStartE),
    .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .StallE(StallE),
    .FlushM(FlushM), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MulDivBusy(MulDivBusy), .MulDivDoneE(MulDivDoneE), .StallCount(StallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no $finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  function automatic logic [16:0] obs();
    return {StallF, StallD, FlushE, StallE, FlushM, ForwardAD, ForwardBD,
            ForwardAE, ForwardBE, MulDivBusy, MulDivDoneE, StallCount};
  endfunction

  task automatic clr_inputs();
    RsD = 0; RtD = 0; BranchD = 0; RsE = 0; RtE = 0; WriteRegE = 0;
    RegWriteE = 0; MemtoRegE = 0; MulDivStartE = 0; WriteRegM = 0;
    RegWriteM = 0; MemtoRegM = 0; WriteRegW = 0; RegWriteW = 0;
  endtask

  // Records one cycle's expectation. The counter model advances when the expected StallD is 1.
  task automatic push_exp(input logic sf, input logic sd, input logic fe, input logic se,
                          input logic fm, input logic fad, input logic fbd,
                          input logic [1:0] fae, input logic [1:0] fbe,
                          input logic busy, input logic done);
    q_exp.push_back({sf, sd, fe, se, fm, fad, fbd, fae, fbe, busy, done, m_cnt});
    if (sd && (m_cnt != 4'hF)) m_cnt = m_cnt + 4'd1;
  endtask

  task automatic do_reset();
    clr_inputs();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    m_cnt = 4'd0;
  endtask

  task automatic test_reset();
    logic [16:0] got, exp;
    clr_inputs();
    reset = 1'b1;
    m_cnt = 4'd0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      clr_inputs();
      if (i == 1) begin
        MemtoRegE = 1; RtE = 5; RsD = 5; MulDivStartE = 1;
        RegWriteM = 1; WriteRegM = 7; RsE = 7;
        push_exp(0, 0, 1, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0);
      end else begin
        push_exp(0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
      end
      @(negedge clk);
      got = obs(); exp = q_exp.pop_front(); n_run++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset step %0d: got %b required %b", i, got, exp);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    logic [16:0] got, exp;
    for (int i = 0; i < 2; i++) begin
      clr_inputs();
      if (i == 0) begin
        MemtoRegE = 1; RtE = 5; RsD = 5;
        push_exp(1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
      end else begin
        push_exp(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
      end
      @(negedge clk);
      got = obs(); exp = q_exp.pop_front(); n_run++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL load_use step %0d: got %b required %b", i, got, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_forward();
    logic [16:0] got, exp;
    for (int i = 0; i < 4; i++) begin
      clr_inputs();
      case (i)
        0: begin
          RegWriteM = 1; RegWriteW = 1; WriteRegM = 7; WriteRegW = 7; RsE = 7;
          push_exp(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0);
        end
        1: begin
          RegWriteM = 0; RegWriteW = 1; WriteRegM = 7; WriteRegW = 7; RsE = 7;
          push_exp(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
        end
        2: begin
          RegWriteM = 1; RegWriteW = 1; WriteRegM = 0; WriteRegW = 0; RsE = 0;
          push_exp(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        end
        default: begin
          RegWriteM = 1; WriteRegM = 3; RegWriteW = 1; WriteRegW = 4;
          RsE = 4; RtE = 3; RsD = 3; RtD = 4;
          push_exp(0, 0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 0, 0);
        end
      endcase
      @(negedge clk);
      got = obs(); exp = q_exp.pop_front(); n_run++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL forward step %0d: got %b required %b", i, got, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_muldiv();
    logic [16:0] got, exp;
    for (int i = 0; i < 5; i++) begin
      clr_inputs();
      MulDivStartE = (i < 4);
      if (i < 3) begin
        MemtoRegE = 1; RtE = 5; RsD = 5;
      end
      if (i < 3)       push_exp(1, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00, (i > 0), 0);
      else if (i == 3) push_exp(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1);
      else             push_exp(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
      @(negedge clk);
      got = obs(); exp = q_exp.pop_front(); n_run++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL muldiv cycle %0d: got %b required %b", i + 1, got, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] got, exp;
    for (int i = 0; i < 9; i++) begin
      clr_inputs();
      MulDivStartE = (i < 5);
      case (i)
        0, 4:    push_exp(1, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        1, 2, 5, 6:
                 push_exp(1, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1, 0);
        3, 7:    push_exp(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1);
        default: push_exp(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
      endcase
      @(negedge clk);
      got = obs(); exp = q_exp.pop_front(); n_run++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: got %b required %b", i + 1, got, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [16:0] got, exp;
    for (int i = 0; i < 4; i++) begin
      clr_inputs();
      RsD = 2; RtD = 9;
      case (i)
        0: begin
          BranchD = 1; RegWriteE = 1; WriteRegE = 9;
          push_exp(1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        end
        1: begin
          BranchD = 1; RegWriteM = 1; MemtoRegM = 0; WriteRegM = 9;
          push_exp(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0);
        end
        2: begin
          BranchD = 1; RegWriteM = 1; MemtoRegM = 1; WriteRegM = 9;
          push_exp(1, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0);
        end
        default: begin
          BranchD = 0; RegWriteM = 1; MemtoRegM = 1; WriteRegM = 9;
          push_exp(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0);
        end
      endcase
      @(negedge clk);
      got = obs(); exp = q_exp.pop_front(); n_run++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL branch step %0d: got %b required %b", i, got, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [16:0] got, exp;
    for (int i = 0; i < 4; i++) begin
      clr_inputs();
      case (i)
        0: begin
          MulDivStartE = 1;
          push_exp(1, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        end
        1:  push_exp(1, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1, 0);
        2: begin
          reset = 1'b1;
          push_exp(0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
          m_cnt = 4'd0;
        end
        default: begin
          reset = 1'b0;
          push_exp(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        end
      endcase
      @(negedge clk);
      got = obs(); exp = q_exp.pop_front(); n_run++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_mid step %0d: got %b required %b", i, got, exp);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  task automatic test_saturation();
    logic [16:0] got, exp;
    for (int i = 0; i < 21; i++) begin
      clr_inputs();
      if (i < 20) begin
        MemtoRegE = 1; RtE = 6; RtD = 6; RsD = 1;
        push_exp(1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
      end else begin
        push_exp(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
      end
      @(negedge clk);
      got = obs(); exp = q_exp.pop_front(); n_run++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL saturation cycle %0d: got %b required %b", i, got, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    m_cnt = 4'd0;
    clr_inputs();
    reset = 1'b1;
    test_reset();
    test_load_use();
    test_forward();
    do_reset();
    test_muldiv();
    do_reset();
    test_back_to_back();
    do_reset();
    test_branch();
    do_reset();
    test_reset_mid();
    do_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage MIPS pipeline.
- Drives stall, flush and forwarding selects for the F/D, D/E and E/M pipeline registers. FlushE feeds the D-to-E register flush input.
- Adds a multi-cycle MUL/DIV sequencer that holds the E stage for MD_LATENCY cycles.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- MD_LATENCY, 4, cycles a MUL/DIV instruction occupies E (legal range 2..15).
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- RsD  in  5  source register 1 of the instruction in D.
- RtD  in  5  source register 2 of the instruction in D.
- BranchD  in  1  D holds a branch that compares in D.
- RsE  in  5  source register 1 of the instruction in E.
- RtE  in  5  source register 2 of the instruction in E.
- WriteRegE  in  5  destination register of the instruction in E.
- RegWriteE  in  1  E instruction writes the register file.
- MemtoRegE  in  1  E instruction is a load.
- MulDivStartE  in  1  E holds a MUL/DIV instruction.
- WriteRegM  in  5  destination register of the instruction in M.
- RegWriteM  in  1  M instruction writes the register file.
- MemtoRegM  in  1  M instruction is a load.
- WriteRegW  in  5  destination register of the instruction in W.
- RegWriteW  in  1  W instruction writes the register file.
- StallF  out  1  hold PC.
- StallD  out  1  hold F/D register.
- FlushE  out  1  bubble into D/E register.
- StallE  out  1  hold D/E register.
- FlushM  out  1  bubble into E/M register.
- ForwardAD  out  1  D-stage compare operand A taken from M.
- ForwardBD  out  1  D-stage compare operand B taken from M.
- ForwardAE  out  2  ALU operand A select: 00 regfile, 01 W result, 10 M result.
- ForwardBE  out  2  ALU operand B select, same encoding as ForwardAE.
- MulDivBusy  out  1  sequencer in BUSY.
- MulDivDoneE  out  1  MUL/DIV result valid in E this cycle.
- StallCount  out  CNT_W  cycles with StallD=1 since reset.

Behaviour:
- Forwarding (combinational), evaluated separately for A/Rs and B/Rt:
  - ForwardAE = 10 if RegWriteM, WriteRegM!=0 and WriteRegM==RsE.
  - Otherwise ForwardAE = 01 if RegWriteW, WriteRegW!=0 and WriteRegW==RsE.
  - Otherwise 00. M takes priority over W.
  - ForwardAD = RsD!=0 and RegWriteM and WriteRegM==RsD. ForwardBD uses RtD the same way.
- lwstall = MemtoRegE and (RtE==RsD or RtE==RtD).
- branchstall = BranchD and either:
  - RegWriteE and WriteRegE matches RsD or RtD, or
  - MemtoRegM and WriteRegM matches RsD or RtD.
- Sequencer FSM has two states, IDLE and BUSY, with a 4-bit down-counter cnt.
  - IDLE to BUSY when MulDivStartE=1; cnt is loaded with MD_LATENCY-1.
  - In BUSY, cnt decrements each cycle. At cnt==1 the next state is IDLE.
  - MulDivStartE is ignored while in BUSY.
  - A back-to-back MUL/DIV arriving in E the cycle after return to IDLE starts a new sequence immediately.
- mdstall = (IDLE and MulDivStartE) or (BUSY and cnt!=1).
- MulDivDoneE = BUSY and cnt==1. MulDivBusy = (state==BUSY).
- A MUL/DIV instruction occupies E for exactly MD_LATENCY cycles: MD_LATENCY-1 stalled cycles, then the done cycle.
- Stall and flush outputs:
  - StallE = mdstall; FlushM = mdstall.
  - StallF = StallD = lwstall or branchstall or mdstall.
  - FlushE = (lwstall or branchstall) and not mdstall. A held E is never flushed.
- StallCount increments by 1 on each clock edge where StallD=1 and reset=0. It saturates at all-ones and never wraps.
- Reset, including mid-sequence:
  - State goes to IDLE, cnt=0, StallCount=0.
  - While reset=1: StallF, StallD, StallE and FlushM are 0; FlushE is 1; MulDivBusy and MulDivDoneE are 0.
- Forward selects are purely combinational and unaffected by reset.

Test Plan:
- Load-use: MemtoRegE=1, RtE=5, RsD=5 → StallF=StallD=FlushE=1 for 1 cycle, StallE=0. StallCount goes 0→1.
- Forward priority: RegWriteM=RegWriteW=1, WriteRegM=WriteRegW=RsE=7 → ForwardAE=10. With RegWriteM=0 → 01. With RsE=0 and all writes to reg 0 → 00.
- MUL/DIV, MD_LATENCY=4: MulDivStartE=1 held 4 cycles → StallE/StallD/FlushM=1 on cycles 1-3, MulDivDoneE=1 on cycle 4 only, MulDivBusy=1 on cycles 2-4. FlushE stays 0 even with concurrent lwstall inputs.
- Branch hazard: BranchD=1, RegWriteE=1, WriteRegE=RtD=9 → StallD=FlushE=1. Next cycle, with the producer now in M (RegWriteM=1, MemtoRegM=0, WriteRegM=9) → no stall and ForwardBD=1.
- Reset mid-sequence: assert reset during BUSY cnt=2 → next cycle MulDivBusy=0, StallCount=0; FlushE=1 while reset is high.
- Saturation, CNT_W=4: hold lwstall for 20 cycles → StallCount reaches 15 and stays at 15.
